// File: rtl/cmp_arbiter.sv
// Four-requester arbiter sharing one unsigned 4-bit comparator (IDLE -> GRANT -> RESULT).
// Define CMP_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module cmp_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] a0,
    input  logic [3:0] a1,
    input  logic [3:0] a2,
    input  logic [3:0] a3,
    input  logic [3:0] b0,
    input  logic [3:0] b1,
    input  logic [3:0] b2,
    input  logic [3:0] b3,
    output logic [3:0] gnt,
    output logic       rslt_valid,
    output logic [1:0] rslt_id,
    output logic       gre,
    output logic       less,
    output logic       eq,
    output logic       leq,
    output logic       geq,
    output logic       noteq
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0] state_r;
    logic [3:0] op_a_r;
    logic [3:0] op_b_r;
    logic       win_any_s;
    logic [1:0] win_idx_s;
    logic [3:0] sel_a_s;
    logic [3:0] sel_b_s;
    logic [5:0] flags_s;

    // Flag order: {gre, less, eq, leq, geq, noteq}
    function automatic logic [5:0] compare(input logic [3:0] a, input logic [3:0] b);
        logic gt_v;
        logic lt_v;
        logic eq_v;
        gt_v    = (a > b);
        lt_v    = (a < b);
        eq_v    = (a == b);
        compare = {gt_v, lt_v, eq_v, lt_v | eq_v, gt_v | eq_v, ~eq_v};
    endfunction

`ifdef CMP_ARB_RR_EN
    logic [1:0] ptr_r;

    // Highest-index candidate is visited first so the one nearest the pointer wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx_v;
        pick = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx_v = p + 2'(k);
            if (r[idx_v]) begin
                pick = idx_v;
            end else begin
                pick = pick;
            end
        end
    endfunction

    // Round-robin pointer advances past each granted requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= 2'd0;
        end else if ((state_r == IDLE) && win_any_s) begin
            ptr_r <= win_idx_s + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Winner selection starting at the pointer
    always_comb begin
        win_any_s = |req;
        win_idx_s = pick(req, ptr_r);
    end
`else
    function automatic logic [1:0] pick(input logic [3:0] r);
        pick = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r[k]) begin
                pick = 2'(k);
            end else begin
                pick = pick;
            end
        end
    endfunction

    // Winner selection, lowest index first
    always_comb begin
        win_any_s = |req;
        win_idx_s = pick(req);
    end
`endif

    // Operand mux feeding the capture registers
    always_comb begin
        sel_a_s = 4'd0;
        sel_b_s = 4'd0;
        case (win_idx_s)
            2'd0:    begin sel_a_s = a0; sel_b_s = b0; end
            2'd1:    begin sel_a_s = a1; sel_b_s = b1; end
            2'd2:    begin sel_a_s = a2; sel_b_s = b2; end
            2'd3:    begin sel_a_s = a3; sel_b_s = b3; end
            default: begin sel_a_s = 4'd0; sel_b_s = 4'd0; end
        endcase
    end

    // The single shared comparator works only on captured operands
    always_comb begin
        flags_s = compare(op_a_r, op_b_r);
    end

    // Arbitration FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gnt        <= 4'd0;
            rslt_valid <= 1'b0;
            rslt_id    <= 2'd0;
            op_a_r     <= 4'd0;
            op_b_r     <= 4'd0;
            {gre, less, eq, leq, geq, noteq} <= 6'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    rslt_valid <= 1'b0;
                    if (win_any_s) begin
                        gnt     <= 4'b0001 << win_idx_s;
                        op_a_r  <= sel_a_s;
                        op_b_r  <= sel_b_s;
                        rslt_id <= win_idx_s;
                        state_r <= GRANT;
                    end else begin
                        gnt     <= 4'd0;
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    gnt        <= 4'd0;
                    rslt_valid <= 1'b1;
                    {gre, less, eq, leq, geq, noteq} <= flags_s;
                    state_r    <= RESULT;
                end
                RESULT: begin
                    gnt        <= 4'd0;
                    rslt_valid <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    gnt        <= 4'd0;
                    rslt_valid <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_cmp_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [3:0] gnt;
    logic       rslt_valid;
    logic [1:0] rslt_id;
    logic       gre, less, eq, leq, geq, noteq;
    logic [12:0] obs;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: arbitration pointer and the values the outputs should be holding
    int         m_ptr;
    logic [1:0] m_id;
    logic [5:0] m_flags;

    cmp_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .gnt(gnt), .rslt_valid(rslt_valid), .rslt_id(rslt_id),
        .gre(gre), .less(less), .eq(eq), .leq(leq), .geq(geq), .noteq(noteq)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, rslt_valid, rslt_id, gre, less, eq, leq, geq, noteq};

    function automatic int pick(input logic [3:0] r, input int p);
        pick = -1;
`ifdef CMP_ARB_RR_EN
        for (int k = 0; k < 4; k++)
            if (pick < 0 && r[(p + k) % 4]) pick = (p + k) % 4;
`else
        for (int k = 0; k < 4; k++)
            if (pick < 0 && r[k]) pick = k;
`endif
    endfunction

    function automatic logic [5:0] flags_of(input int a, input int b);
        return {a > b, a < b, a == b, a <= b, a >= b, a != b};
    endfunction

    function automatic logic [3:0] get_a(input int i);
        case (i)
            0: get_a = a0;
            1: get_a = a1;
            2: get_a = a2;
            default: get_a = a3;
        endcase
    endfunction

    function automatic logic [3:0] get_b(input int i);
        case (i)
            0: get_b = b0;
            1: get_b = b1;
            2: get_b = b2;
            default: get_b = b3;
        endcase
    endfunction

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        case (i)
            0: begin a0 = a; b0 = b; end
            1: begin a1 = a; b1 = b; end
            2: begin a2 = a; b2 = b; end
            default: begin a3 = a; b3 = b; end
        endcase
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < 4; i++) set_op(i, 4'($urandom), 4'($urandom));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        tick();
        tick();
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_id    = 2'd0;
        m_flags = 6'd0;
    endtask

    // One full request cycle: grant edge, result edge, return-to-idle edge
    task automatic run_txn(input logic [3:0] r, input bit scramble, input string name, output int w);
        logic [3:0] la, lb, oh;
        logic [12:0] exp_v;
        req = r;
        w   = pick(r, m_ptr);
        if (w < 0) begin
            tick();
            exp_v = {4'd0, 1'b0, m_id, m_flags};
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL %s idle: got %b expected %b", name, obs, exp_v);
            end
            return;
        end
        la    = get_a(w);
        lb    = get_b(w);
        oh    = 4'b0001 << w;
        m_id  = 2'(w);
        m_ptr = (w + 1) % 4;
        tick();
        exp_v = {oh, 1'b0, m_id, m_flags};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s grant: got %b expected %b", name, obs, exp_v);
        end
        if (scramble) begin
            randomize_ops();
            set_op(w, 4'd0, ~lb);
            req = 4'($urandom);
        end
        m_flags = flags_of(la, lb);
        tick();
        exp_v = {4'd0, 1'b1, m_id, m_flags};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s result: got %b expected %b", name, obs, exp_v);
        end
        if (scramble) req = 4'($urandom);
        tick();
        exp_v = {4'd0, 1'b0, m_id, m_flags};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s hold: got %b expected %b", name, obs, exp_v);
        end
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        req   = 4'hf;
        randomize_ops();
        tick();
        tick();
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 13'd0);
        end
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_id    = 2'd0;
        m_flags = 6'd0;
        run_txn(4'b0010, 1'b0, "first_after_reset", w);
        req = 4'd0;
    endtask

    task automatic test_single();
        int w;
        do_reset();
        randomize_ops();
        set_op(0, 4'd6, 4'd8);
        run_txn(4'b0001, 1'b0, "single", w);
        req = 4'd0;
        tests_run++;
        if ({rslt_id, gre, less, eq, leq, geq, noteq} !== {2'd0, 6'b010101}) begin
            tests_failed++;
            $display("FAIL single_flags: got %b expected %b", {rslt_id, gre, less, eq, leq, geq, noteq}, {2'd0, 6'b010101});
        end
    endtask

    task automatic test_equal();
        int w;
        do_reset();
        for (int v = 0; v < 2; v++) begin
            set_op(2, (v == 0) ? 4'd5 : 4'd0, (v == 0) ? 4'd5 : 4'd0);
            run_txn(4'b0100, 1'b0, "equal", w);
            req = 4'd0;
            tests_run++;
            if ({rslt_id, gre, less, eq, leq, geq, noteq} !== {2'd2, 6'b001110}) begin
                tests_failed++;
                $display("FAIL equal_flags: got %b expected %b", {rslt_id, gre, less, eq, leq, geq, noteq}, {2'd2, 6'b001110});
            end
        end
    endtask

    task automatic test_operand_hold();
        int w;
        do_reset();
        set_op(0, 4'd9, 4'd3);
        run_txn(4'b0001, 1'b1, "operand_hold", w);
        req = 4'd0;
        tests_run++;
        if ({gre, less, eq, leq, geq, noteq} !== 6'b100011) begin
            tests_failed++;
            $display("FAIL operand_hold_flags: got %b expected %b", {gre, less, eq, leq, geq, noteq}, 6'b100011);
        end
    endtask

    task automatic test_contention();
        int w;
        int order [5];
        logic [3:0] r;
`ifdef CMP_ARB_RR_EN
        r = 4'b1111;
        order = '{0, 1, 2, 3, 0};
`else
        r = 4'b1010;
        order = '{1, 1, 1, 1, 1};
`endif
        do_reset();
        randomize_ops();
        for (int n = 0; n < 5; n++) begin
            run_txn(r, 1'b0, "contention", w);
            tests_run++;
            if (w !== order[n]) begin
                tests_failed++;
                $display("FAIL contention_order[%0d]: got %0d expected %0d", n, w, order[n]);
            end
        end
        req = 4'd0;
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        randomize_ops();
        run_txn(4'b0001, 1'b0, "pre_abort", w);
        req = 4'b0010;
        tick();
        tests_run++;
        if (gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL abort_grant: got %b expected %b", gnt, 4'b0010);
        end
        rst_n = 1'b0;
        req   = 4'd0;
        tick();
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got %b expected %b", obs, 13'd0);
        end
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_id    = 2'd0;
        m_flags = 6'd0;
        tick();
        tests_run++;
        if (obs !== 13'd0) begin
            tests_failed++;
            $display("FAIL abort_no_pulse: got %b expected %b", obs, 13'd0);
        end
        run_txn(4'b1111, 1'b0, "abort_pointer", w);
        req = 4'd0;
    endtask

    task automatic test_random();
        int w;
        logic [3:0] r;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            randomize_ops();
            r = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            run_txn(r, 1'b1, "random", w);
        end
        req = 4'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'd0;
        {a0, a1, a2, a3, b0, b1, b2, b3} = 32'd0;
        test_reset();
        test_single();
        test_equal();
        test_operand_hold();
        test_contention();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
